// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the serial transmitter, its matching
// receiver and the bench scoreboard.
//   ST_IDLE..ST_STOP : 3-bit frame state encodings
//   state_e          : enum view of those encodings, used for the FSM register
//   FRAME_BITS()     : serial bits per frame (start + data + parity + stop)
package serial_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } state_e;

    // Number of bit periods in one frame; busy spans FRAME_BITS*CLKS_PER_BIT cycles.
    function automatic int FRAME_BITS(input int n, input int parity_en);
        return n + 2 + ((parity_en != 0) ? 1 : 0);
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer: divides clk into serial bit periods.
//   clk, rst_l : clock, asynchronous active-low reset
//   clear      : restart the period from cycle 0 (asserted on frame acceptance)
//   bit_end    : high on the last clk cycle of each bit period
// With CLKS_PER_BIT=1 the counter sits at 0 and bit_end is always high.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_l,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial transmitter.
//   clk, rst_l : clock, asynchronous active-low reset
//   send       : producer request; pdata valid while high (sampled only in IDLE)
//   pdata[N]   : word to transmit, captured on acceptance
//   busy       : high for the whole frame, from the cycle after acceptance
//   sdata      : serial line, idles high; start, N data LSB-first, [even parity], stop
//   done       : one-cycle pulse after the last stop cycle
// All outputs come straight from flops; sdata_q is loaded with the value of the
// next bit on the same edge that changes state, so line and state stay aligned.
module serial_tx
    import serial_pkg::*;
#(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         send,
    input  logic [N-1:0] pdata,
    output logic         busy,
    output logic         sdata,
    output logic         done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [IW-1:0] bit_idx_q, bit_idx_d;
    logic          parity_q, parity_d;
    logic          busy_q, busy_d;
    logic          sdata_q, sdata_d;
    logic          done_q, done_d;

    logic          accept;
    logic          bit_end;
    logic [N-1:0]  shift_nxt;

    assign accept    = (state_q == S_IDLE) && send;
    assign shift_nxt = shift_q >> 1;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst_l   (rst_l),
        .clear   (accept),
        .bit_end (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        parity_d  = parity_q;
        busy_d    = busy_q;
        sdata_d   = sdata_q;
        done_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (send) begin
                    shift_d   = pdata;
                    parity_d  = ^pdata;
                    bit_idx_d = '0;
                    busy_d    = 1'b1;
                    sdata_d   = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    sdata_d   = shift_q[0];
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_nxt;
                    if (bit_idx_q == LAST_IDX) begin
                        if (PARITY_EN != 0) begin
                            sdata_d = parity_q;
                            state_d = S_PARITY;
                        end else begin
                            sdata_d = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                        sdata_d   = shift_nxt[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    sdata_d = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sdata_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                sdata_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            busy_q    <= 1'b0;
            sdata_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            parity_q  <= parity_d;
            busy_q    <= busy_d;
            sdata_q   <= sdata_d;
            done_q    <= done_d;
        end
    end

    assign busy  = busy_q;
    assign sdata = sdata_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: dut_a (N=8, 4 clk/bit, parity) and dut_b (N=8, 1 clk/bit,
// no parity). Inputs change and outputs are sampled on the falling edge.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       send_a = 1'b0, send_b = 1'b0;
    logic [7:0] pdata_a = '0, pdata_b = '0;
    logic       busy_a, sdata_a, done_a;
    logic       busy_b, sdata_b, done_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_tx #(.N(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
        .clk(clk), .rst_l(rst_l), .send(send_a), .pdata(pdata_a),
        .busy(busy_a), .sdata(sdata_a), .done(done_a)
    );

    serial_tx #(.N(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
        .clk(clk), .rst_l(rst_l), .send(send_b), .pdata(pdata_b),
        .busy(busy_b), .sdata(sdata_b), .done(done_b)
    );

    // Expected line value for bit period idx of a frame carrying w.
    function automatic logic exp_bit(input logic [7:0] w, input int idx, input int pen);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (pen != 0 && idx == 9) return ^w;
        return 1'b1;
    endfunction

    // Present a word at a falling edge; the next rising edge accepts it.
    // Returns at the falling edge just after acceptance.
    task automatic start_frame(input bit sel, input logic [7:0] w, input bit hold);
        if (sel) begin send_b = 1'b1; pdata_b = w; end
        else     begin send_a = 1'b1; pdata_a = w; end
        @(negedge clk);
        if (!hold) begin
            if (sel) send_b = 1'b0; else send_a = 1'b0;
        end
    endtask

    // Checks every cycle of a frame already accepted, ending on the done cycle.
    // With hold set, pdata is scrambled every cycle while send stays high.
    task automatic run_frame(input bit sel, input logic [7:0] w, input bit hold, input string nm);
        int c   = sel ? 1 : 4;
        int pen = sel ? 0 : 1;
        int len = sel ? 10 : 44;
        logic ob, os, od, es;
        for (int k = 0; k < len; k++) begin
            ob = sel ? busy_b : busy_a;
            os = sel ? sdata_b : sdata_a;
            od = sel ? done_b : done_a;
            es = exp_bit(w, k / c, pen);
            n_tests++;
            if (ob !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy cyc%0d: got %b want 1", nm, k, ob);
            end
            n_tests++;
            if (os !== es) begin
                n_fail++;
                $display("FAIL %s sdata cyc%0d: got %b want %b", nm, k, os, es);
            end
            n_tests++;
            if (od !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early done cyc%0d: got %b want 0", nm, k, od);
            end
            if (hold) begin
                if (sel) pdata_b = 8'(k * 29 + 3); else pdata_a = 8'(k * 29 + 3);
            end
            @(negedge clk);
        end
        ob = sel ? busy_b : busy_a;
        os = sel ? sdata_b : sdata_a;
        od = sel ? done_b : done_a;
        n_tests++;
        if (ob !== 1'b0 || od !== 1'b1 || os !== 1'b1) begin
            n_fail++;
            $display("FAIL %s end: busy/done/sdata got %b%b%b want 011", nm, ob, od, os);
        end
    endtask

    task automatic check_idle(input bit sel, input string nm);
        logic ob, os, od;
        ob = sel ? busy_b : busy_a;
        os = sel ? sdata_b : sdata_a;
        od = sel ? done_b : done_a;
        n_tests++;
        if (ob !== 1'b0 || od !== 1'b0 || os !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle: busy/done/sdata got %b%b%b want 001", nm, ob, od, os);
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle(1'b0, "reset_a");
            check_idle(1'b1, "reset_b");
        end
        rst_l = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle(1'b0, "post_reset_a");
            check_idle(1'b1, "post_reset_b");
        end
    endtask

    task automatic test_frame_content();
        start_frame(1'b0, 8'hA5, 1'b0);
        run_frame(1'b0, 8'hA5, 1'b0, "frame_A5");
        @(negedge clk);
        check_idle(1'b0, "after_A5");
    endtask

    task automatic test_parity();
        start_frame(1'b0, 8'h07, 1'b0);
        run_frame(1'b0, 8'h07, 1'b0, "frame_07");
        @(negedge clk);
        check_idle(1'b0, "after_07");
        start_frame(1'b0, 8'h00, 1'b0);
        run_frame(1'b0, 8'h00, 1'b0, "frame_00");
        @(negedge clk);
        check_idle(1'b0, "after_00");
    endtask

    task automatic test_ignored_request();
        start_frame(1'b0, 8'h3C, 1'b1);
        run_frame(1'b0, 8'h3C, 1'b1, "hold_3C");
        // send is still high; this pdata is what the next frame must carry
        pdata_a = 8'h96;
        @(negedge clk);
        send_a = 1'b0;
        run_frame(1'b0, 8'h96, 1'b0, "b2b_96");
        @(negedge clk);
        check_idle(1'b0, "after_96");
    endtask

    task automatic test_reset_midframe();
        start_frame(1'b0, 8'hFF, 1'b0);
        // data bit 3 spans cycles 16..19 of the frame
        for (int k = 0; k < 17; k++) @(negedge clk);
        n_tests++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe pre-reset busy: got %b want 1", busy_a);
        end
        rst_l = 1'b0;
        #1;
        check_idle(1'b0, "midframe_async");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_idle(1'b0, "midframe_hold");
        end
        rst_l = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            check_idle(1'b0, "midframe_release");
        end
        start_frame(1'b0, 8'h81, 1'b0);
        run_frame(1'b0, 8'h81, 1'b0, "frame_81");
        @(negedge clk);
        check_idle(1'b0, "after_81");
    endtask

    task automatic test_config_corner();
        start_frame(1'b1, 8'h5A, 1'b0);
        run_frame(1'b1, 8'h5A, 1'b0, "fast_5A");
        @(negedge clk);
        check_idle(1'b1, "after_5A");
    endtask

    initial begin
        test_reset();
        test_frame_content();
        test_parity();
        test_ignored_request();
        test_reset_midframe();
        test_config_corner();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
